instruction_prefetch: RTL and testbench
=======================================

INSTRUCTION_PREFETCH -- requirements
Module: instruction_prefetch

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 16, word-address width.
REQ-003 SHALL have parameter DEPTH, default 4, prefetch buffer entries (power of two, >=2).
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port cs  in  1  fetch enable; low = no new memory reads, buffer still drains.
REQ-008 SHALL have port redirect  in  1  one-cycle branch/jump request.
REQ-009 SHALL have port redirect_pc  in  ADDR_W  target address, valid with redirect.
REQ-010 SHALL have port mem_rd  out  1  memory read strobe.
REQ-011 SHALL have port mem_address  out  ADDR_W  memory word address.
REQ-012 SHALL have port mem_read_data  in  DATA_W  memory data, valid the cycle after mem_rd.
REQ-013 SHALL have port instr_valid  out  1  buffer head holds an instruction.
REQ-014 SHALL have port instr_ready  in  1  consumer accepts head when instr_valid high.
REQ-015 SHALL have port instruction  out  DATA_W  head instruction word.
REQ-016 SHALL have port instr_pc  out  ADDR_W  address the head word was fetched from.
REQ-017 SHALL have port fifo_count  out  $clog2(DEPTH)+1  buffered entries.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, STALL; reset -> IDLE.
REQ-019 IDLE -> RUN when cs=1; RUN -> IDLE when cs=0; RUN -> STALL when fifo_count + inflight == DEPTH; STALL -> RUN when a pop frees a credit.
REQ-020 SHALL assert mem_rd with mem_address=fetch_pc only in RUN with a free credit and no redirect this cycle; fetch_pc then increments by 1.
REQ-021 fetch_pc SHALL wrap from 2^ADDR_W-1 to 0.
REQ-022 Data returned the cycle after mem_rd SHALL be pushed into the buffer with its fetch address; read-to-instr_valid latency is exactly 2 cycles.
REQ-023 A pop SHALL occur when instr_valid & instr_ready; push and pop in the same cycle SHALL leave fifo_count unchanged.
REQ-024 The buffer SHALL never overflow; credit = DEPTH - fifo_count - inflight (inflight 0 or 1).
REQ-025 On redirect: buffer cleared, any in-flight response discarded, fetch_pc := redirect_pc, mem_rd low that cycle; first read of redirect_pc the next cycle if cs=1.
REQ-026 redirect SHALL take priority over simultaneous pop, push, and issue; a pop in the redirect cycle is ignored.
REQ-027 instr_valid SHALL be low when fifo_count=0; instruction/instr_pc hold the last head value when invalid.
REQ-028 cs falling with a read in flight SHALL still push that response.

Reset
REQ-029 reset SHALL dominate redirect and all other inputs.
REQ-030 Reset values: mem_rd=0, mem_address=RESET_PC, instr_valid=0, instruction=0, instr_pc=0, fifo_count=0, fetch_pc=RESET_PC, inflight=0, state IDLE.
REQ-031 reset mid-operation SHALL discard buffer and in-flight read; first read after release is RESET_PC.

Structure
REQ-032 Shared package SHALL hold FSM state encoding and default width constants (DATA_W, ADDR_W).
REQ-033 Buffer SHALL be one sub-module prefetch_fifo (DEPTH x (DATA_W+ADDR_W), push/pop/clear/count).

Verification
REQ-034 Memory preloaded 0x0,0x1,0x10,0x6 at addresses 0..3, cs=1, instr_ready=1 after reset -> instructions 0x0,0x1,0x10,0x6 with instr_pc 0..3, first instr_valid 2 cycles after first mem_rd.
REQ-035 instr_ready=0, DEPTH=4 -> exactly 4 reads issued, fifo_count=4, mem_rd low (STALL); one pop -> exactly one new read.
REQ-036 redirect with redirect_pc=0x20 while 3 entries buffered and a read in flight -> fifo_count=0 next cycle, next mem_address=0x20, stale data never appears.
REQ-037 fetch_pc=0xFFFF, ADDR_W=16 -> reads 0xFFFF then 0x0000 with matching instr_pc.
REQ-038 reset asserted with 2 entries buffered and redirect high -> all outputs at reset values; after release first mem_address=RESET_PC.
REQ-039 cs toggled low for 5 cycles -> no mem_rd, buffer drains to 0, fetch resumes at next sequential address.

Source files
------------

// File: rtl/instruction_prefetch_pkg.sv
// Shared definitions for the instruction prefetch unit: FSM state encoding
// and the default word/address widths.
package instruction_prefetch_pkg;

  localparam int PF_DATA_W = 32;
  localparam int PF_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

endpackage

// File: rtl/instruction_prefetch_fifo.sv
// prefetch_fifo: small first-word-fall-through buffer holding {data, pc}
// entries. The head is read combinationally so a freshly pushed word is
// visible on the very next cycle; the storage stays tiny (DEPTH entries).
module prefetch_fifo #(
  parameter  int WIDTH = 48,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             pop_ok;

  // A pop on an empty buffer is ignored so the pointers can never skew.
  assign pop_ok = pop && (count_reg != '0);

  // Storage write; no reset needed, occupancy is tracked by count_reg.
  always_ff @(posedge clk) begin
    if (push && !clear && !reset) begin
      storage[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy update; clear empties the buffer in one cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = storage[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/instruction_prefetch.sv
// instruction_prefetch: sequential instruction fetcher with credit-based
// flow control into a small prefetch buffer, branch redirect and a
// one-cycle-latency memory interface.
module instruction_prefetch
  import instruction_prefetch_pkg::*;
#(
  parameter  int DATA_W   = PF_DATA_W,
  parameter  int ADDR_W   = PF_ADDR_W,
  parameter  int DEPTH    = 4,
  parameter  int RESET_PC = 0,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [CNT_W-1:0]  fifo_count
);

  state_t              state_reg;
  state_t              state_next;
  logic [ADDR_W-1:0]   fetch_pc_reg;
  logic                inflight_reg;
  logic [ADDR_W-1:0]   inflight_pc_reg;
  logic [DATA_W-1:0]   last_data_reg;
  logic [ADDR_W-1:0]   last_pc_reg;

  logic [DATA_W+ADDR_W-1:0] head;
  logic [DATA_W-1:0]   head_data;
  logic [ADDR_W-1:0]   head_pc;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    occupancy;
  logic                has_credit;
  logic                fire;
  logic                push;
  logic                pop;

  // A slot is reserved for every outstanding read, so the buffer can
  // never be overrun by a response.
  assign occupancy  = count + {{(CNT_W-1){1'b0}}, inflight_reg};
  assign has_credit = occupancy < CNT_W'(DEPTH);

  assign instr_valid = (count != '0);
  assign fire        = instr_valid && instr_ready;

  // Redirect wins over everything: the response in flight this cycle and
  // any consumer pop are both dropped while the buffer is flushed.
  assign push = inflight_reg && !redirect;
  assign pop  = fire && !redirect;

  assign mem_rd      = !reset && !redirect && cs && (state_reg == RUN) && has_credit;
  assign mem_address = fetch_pc_reg;

  prefetch_fifo #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect),
    .push      (push),
    .push_data ({mem_read_data, inflight_pc_reg}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign head_data   = head[DATA_W+ADDR_W-1:ADDR_W];
  assign head_pc     = head[ADDR_W-1:0];
  assign instruction = instr_valid ? head_data : last_data_reg;
  assign instr_pc    = instr_valid ? head_pc   : last_pc_reg;
  assign fifo_count  = count;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a redirect empties the buffer so it always ends a stall.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cs) state_next = RUN;
      RUN:     if (!cs) state_next = IDLE;
               else if (!has_credit && !fire) state_next = STALL;
      STALL:   if (!cs) state_next = IDLE;
               else if (fire || has_credit) state_next = RUN;
      default: state_next = IDLE;
    endcase
    if (redirect) begin
      state_next = cs ? RUN : IDLE;
    end
  end

  // Fetch address and outstanding-read tracking; the pc wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg    <= ADDR_W'(RESET_PC);
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
    end else begin
      inflight_reg <= mem_rd;
      if (redirect) begin
        fetch_pc_reg <= redirect_pc;
      end else if (mem_rd) begin
        fetch_pc_reg    <= fetch_pc_reg + 1'b1;
        inflight_pc_reg <= fetch_pc_reg;
      end
    end
  end

  // Remember the most recent head so the outputs hold while the buffer is empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_data_reg <= '0;
      last_pc_reg   <= '0;
    end else if (instr_valid) begin
      last_data_reg <= head_data;
      last_pc_reg   <= head_pc;
    end
  end

endmodule

// File: tb/tb_instruction_prefetch.sv
// Directed bench for instruction_prefetch: a cycle-by-cycle vector table
// followed by hand-written sequences for address wrap and stall refill.
module tb_instruction_prefetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        mem_rd;
  logic [15:0] mem_address;
  logic [31:0] mem_read_data = '0;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [15:0] instr_pc;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_prefetch #(
    .DATA_W   (32),
    .ADDR_W   (16),
    .DEPTH    (4),
    .RESET_PC (0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cs            (cs),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .mem_rd        (mem_rd),
    .mem_address   (mem_address),
    .mem_read_data (mem_read_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instruction   (instruction),
    .instr_pc      (instr_pc),
    .fifo_count    (fifo_count)
  );

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    case (a)
      16'd0:   return 32'h0;
      16'd1:   return 32'h1;
      16'd2:   return 32'h10;
      16'd3:   return 32'h6;
      default: return 32'hA000_0000 | {16'h0, a};
    endcase
  endfunction

  // Memory model: data is returned the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_read_data <= mem_word(mem_address);
  end

  typedef struct {
    logic        rst;
    logic        cs;
    logic        redir;
    logic [15:0] rpc;
    logic        rdy;
    logic        e_rd;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [15:0] e_pc;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic c, input logic rd, input logic [15:0] rpc,
                     input logic rdy, input logic e_rd, input logic [15:0] e_addr,
                     input logic e_valid, input logic [31:0] e_instr, input logic [15:0] e_pc,
                     input logic [2:0] e_cnt);
    vec_t v;
    v.rst = rst; v.cs = c; v.redir = rd; v.rpc = rpc; v.rdy = rdy;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_pc = e_pc; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int reads;
    logic [31:0] a4;
    a4 = 32'hA000_0004;

    //  rst cs red rpc    rdy | rd addr   valid instr          pc     cnt
    add(1, 1, 1, 16'h55, 1,   0, 16'h0,  0, 32'h0,          16'h0,  3'd0); // reset dominates
    add(0, 1, 0, 16'h0,  1,   0, 16'h0,  0, 32'h0,          16'h0,  3'd0); // IDLE
    add(0, 1, 0, 16'h0,  1,   1, 16'h0,  0, 32'h0,          16'h0,  3'd0);
    add(0, 1, 0, 16'h0,  1,   1, 16'h1,  0, 32'h0,          16'h0,  3'd0);
    add(0, 1, 0, 16'h0,  1,   1, 16'h2,  1, 32'h0,          16'h0,  3'd1); // 2 cycles after 1st read
    add(0, 1, 0, 16'h0,  1,   1, 16'h3,  1, 32'h1,          16'h1,  3'd1);
    add(0, 1, 0, 16'h0,  1,   1, 16'h4,  1, 32'h10,         16'h2,  3'd1);
    add(0, 1, 0, 16'h0,  1,   1, 16'h5,  1, 32'h6,          16'h3,  3'd1);
    add(0, 1, 0, 16'h0,  0,   1, 16'h6,  1, a4,             16'h4,  3'd1); // consumer stops
    add(0, 1, 0, 16'h0,  0,   1, 16'h7,  1, a4,             16'h4,  3'd2);
    add(0, 1, 0, 16'h0,  0,   0, 16'h8,  1, a4,             16'h4,  3'd3);
    add(0, 1, 0, 16'h0,  0,   0, 16'h8,  1, a4,             16'h4,  3'd4); // full, stalled
    add(0, 1, 0, 16'h0,  0,   0, 16'h8,  1, a4,             16'h4,  3'd4);
    add(0, 1, 0, 16'h0,  1,   0, 16'h8,  1, a4,             16'h4,  3'd4); // one pop
    add(0, 1, 0, 16'h0,  0,   1, 16'h8,  1, 32'hA000_0005,  16'h5,  3'd3); // one refill read
    add(0, 1, 0, 16'h0,  0,   0, 16'h9,  1, 32'hA000_0005,  16'h5,  3'd3);
    add(0, 1, 0, 16'h0,  0,   0, 16'h9,  1, 32'hA000_0005,  16'h5,  3'd4);
    add(0, 1, 0, 16'h0,  1,   0, 16'h9,  1, 32'hA000_0005,  16'h5,  3'd4);
    add(0, 1, 0, 16'h0,  0,   1, 16'h9,  1, 32'hA000_0006,  16'h6,  3'd3); // 3 buffered + read
    add(0, 1, 1, 16'h20, 1,   0, 16'ha,  1, 32'hA000_0006,  16'h6,  3'd3); // redirect
    add(0, 1, 0, 16'h0,  1,   1, 16'h20, 0, 32'hA000_0006,  16'h6,  3'd0); // flushed, head held
    add(0, 1, 0, 16'h0,  1,   1, 16'h21, 0, 32'hA000_0006,  16'h6,  3'd0); // stale data dropped
    add(0, 1, 0, 16'h0,  1,   1, 16'h22, 1, 32'hA000_0020,  16'h20, 3'd1);
    add(0, 1, 0, 16'h0,  0,   1, 16'h23, 1, 32'hA000_0021,  16'h21, 3'd1);
    add(1, 1, 1, 16'h55, 0,   0, 16'h24, 1, 32'hA000_0021,  16'h21, 3'd2); // reset + redirect
    add(0, 1, 0, 16'h0,  0,   0, 16'h0,  0, 32'h0,          16'h0,  3'd0); // reset values
    add(0, 1, 0, 16'h0,  0,   1, 16'h0,  0, 32'h0,          16'h0,  3'd0); // RESET_PC first
    add(0, 1, 0, 16'h0,  0,   1, 16'h1,  0, 32'h0,          16'h0,  3'd0);
    add(0, 0, 0, 16'h0,  1,   0, 16'h2,  1, 32'h0,          16'h0,  3'd1); // cs low
    add(0, 0, 0, 16'h0,  1,   0, 16'h2,  1, 32'h1,          16'h1,  3'd1); // in-flight pushed
    add(0, 0, 0, 16'h0,  1,   0, 16'h2,  0, 32'h1,          16'h1,  3'd0);
    add(0, 0, 0, 16'h0,  1,   0, 16'h2,  0, 32'h1,          16'h1,  3'd0);
    add(0, 0, 0, 16'h0,  1,   0, 16'h2,  0, 32'h1,          16'h1,  3'd0);
    add(0, 1, 0, 16'h0,  1,   0, 16'h2,  0, 32'h1,          16'h1,  3'd0);
    add(0, 1, 0, 16'h0,  1,   1, 16'h2,  0, 32'h1,          16'h1,  3'd0); // resumes at 2
    add(0, 1, 0, 16'h0,  1,   1, 16'h3,  0, 32'h1,          16'h1,  3'd0);
    add(0, 1, 0, 16'h0,  1,   1, 16'h4,  1, 32'h10,         16'h2,  3'd1);

    reset = 1'b1; cs = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      reset = vecs[i].rst; cs = vecs[i].cs; redirect = vecs[i].redir;
      redirect_pc = vecs[i].rpc; instr_ready = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("v%0d mem_rd", i),      32'(mem_rd),      32'(vecs[i].e_rd));
      check($sformatf("v%0d mem_address", i), 32'(mem_address), 32'(vecs[i].e_addr));
      check($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d instruction", i), instruction,      vecs[i].e_instr);
      check($sformatf("v%0d instr_pc", i),    32'(instr_pc),    32'(vecs[i].e_pc));
      check($sformatf("v%0d fifo_count", i),  32'(fifo_count),  32'(vecs[i].e_cnt));
      $display("vec %0d: rd=%0b addr=0x%0h valid=%0b instr=0x%0h pc=0x%0h cnt=%0d",
               i, mem_rd, mem_address, instr_valid, instruction, instr_pc, fifo_count);
      step();
    end

    // Address wrap: redirect to the last word, then fetch crosses to 0.
    cs = 1'b1; instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFF;
    @(negedge clk);
    check("wrap redirect mem_rd", 32'(mem_rd), 32'd0);
    step();
    redirect = 1'b0;
    @(negedge clk);
    check("wrap rd0 mem_rd", 32'(mem_rd), 32'd1);
    check("wrap rd0 addr", 32'(mem_address), 32'hFFFF);
    step();
    @(negedge clk);
    check("wrap rd1 mem_rd", 32'(mem_rd), 32'd1);
    check("wrap rd1 addr", 32'(mem_address), 32'h0000);
    step();
    n = 0;
    @(negedge clk);
    while (!instr_valid && n < 6) begin
      step();
      @(negedge clk);
      n++;
    end
    check("wrap valid within budget", 32'(instr_valid), 32'd1);
    check("wrap head pc", 32'(instr_pc), 32'hFFFF);
    check("wrap head instr", instruction, 32'hA000_FFFF);
    $display("wrap: pc=0x%0h instr=0x%0h", instr_pc, instruction);
    step();
    @(negedge clk);
    check("wrap next pc", 32'(instr_pc), 32'h0);
    check("wrap next instr", instruction, 32'h0);
    $display("wrap: pc=0x%0h instr=0x%0h", instr_pc, instruction);

    // Stall: fill the buffer, then one pop must buy exactly one read.
    instr_ready = 1'b0;
    repeat (8) step();
    @(negedge clk);
    check("stall full count", 32'(fifo_count), 32'd4);
    check("stall mem_rd", 32'(mem_rd), 32'd0);
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
    reads = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_rd) reads++;
      @(posedge clk);
      #1;
    end
    check("stall refill reads", 32'(reads), 32'd1);
    @(negedge clk);
    check("stall refill count", 32'(fifo_count), 32'd4);
    $display("stall: refill reads=%0d count=%0d", reads, fifo_count);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
